// File: rtl/mult_pkg.sv
// Shared types for the unsigned 16x16 Wallace-tree multiplier: operand width,
// partial-product row width and the row-array type passed between stages.
package mult_pkg;
  localparam int N  = 16;
  localparam int PW = 2 * N;

  typedef logic [PW-1:0] pp_row_t;
  typedef pp_row_t pp_arr_t [N];
endpackage

// File: rtl/ppg_row.sv
// One partial-product row: X zero-extended to PW bits, shifted left by IDX,
// and gated by the corresponding multiplier bit. Purely combinational.
module ppg_row
  import mult_pkg::*;
#(
  parameter int IDX = 0
) (
  input  logic [N-1:0] x,
  input  logic         ybit,
  output pp_row_t      row
);

  // Zero-extending before the shift keeps the top row untruncated.
  pp_row_t x_ext;
  assign x_ext = {{N{1'b0}}, x};
  assign row   = ybit ? (x_ext << IDX) : '0;

endmodule

// File: rtl/ppg.sv
// Partial-product generator: forms all N AND-gated, shifted copies of X and
// registers them together with the valid flag, giving one clock of latency.
module ppg
  import mult_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_vld,
  input  logic [N-1:0] X,
  input  logic [N-1:0] Y,
  output logic         out_vld,
  output pp_arr_t      PP
);

  pp_arr_t pp_next;
  pp_arr_t pp_reg;
  logic    vld_reg;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_row
      ppg_row #(.IDX(gi)) u_row (
        .x    (X),
        .ybit (Y[gi]),
        .row  (pp_next[gi])
      );

      // Rows load every edge; in_vld only qualifies the data downstream.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          pp_reg[gi] <= '0;
        end else begin
          pp_reg[gi] <= pp_next[gi];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_reg <= 1'b0;
    end else begin
      vld_reg <= in_vld;
    end
  end

  assign out_vld = vld_reg;
  assign PP      = pp_reg;

endmodule

// File: tb/tb_ppg.sv
// Self-checking bench for ppg: scoreboard of expected rows/sums pushed at drive
// time and compared one edge later, plus an asynchronous-reset scenario.
module tb_ppg;
  import mult_pkg::*;

  typedef struct packed {
    logic              vld;
    logic [31:0]       sum;
    logic [15:0][31:0] rows;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        in_vld;
  logic [15:0] x;
  logic [15:0] y;
  logic        out_vld;
  pp_arr_t     pp;

  int checks   = 0;
  int failures = 0;
  exp_t sb[$];

  ppg dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_vld  (in_vld),
    .X       (x),
    .Y       (y),
    .out_vld (out_vld),
    .PP      (pp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0][31:0] model_rows(logic [15:0] a, logic [15:0] b);
    logic [15:0][31:0] r;
    for (int i = 0; i < 16; i++) r[i] = b[i] ? ({16'h0, a} << i) : 32'h0;
    return r;
  endfunction

  function automatic logic [15:0][31:0] observed_rows();
    logic [15:0][31:0] r;
    for (int i = 0; i < 16; i++) r[i] = pp[i];
    return r;
  endfunction

  function automatic logic [31:0] sum_rows(logic [15:0][31:0] r);
    logic [31:0] s = 32'h0;
    for (int i = 0; i < 16; i++) s = s + r[i];
    return s;
  endfunction

  function automatic exp_t model_exp(logic v, logic [15:0] a, logic [15:0] b);
    exp_t e;
    e.vld  = v;
    e.sum  = 32'(a) * 32'(b);
    e.rows = model_rows(a, b);
    return e;
  endfunction

  task automatic test_reset();
    logic [15:0][31:0] obs;
    rst_n = 1'b0; in_vld = 1'b0; x = '0; y = '0;
    #1;
    obs = observed_rows();
    checks++;
    if (out_vld !== 1'b0 || obs !== '0) begin
      failures++;
      $display("FAIL reset_initial out_vld=%b rows=%h required out_vld=0 rows=0", out_vld, obs);
    end
    @(negedge clk); rst_n = 1'b1;
    in_vld = 1'b1; x = 16'hFFFF; y = 16'hFFFF;
    @(posedge clk); #2;
    checks++;
    if (pp[0] !== 32'h0000FFFF || out_vld !== 1'b1) begin
      failures++;
      $display("FAIL reset_preload pp0=%h out_vld=%b required pp0=0000ffff out_vld=1", pp[0], out_vld);
    end
    // Mid-cycle async assertion: no clock edge between here and the check.
    rst_n = 1'b0;
    #1;
    obs = observed_rows();
    checks++;
    if (out_vld !== 1'b0 || obs !== '0) begin
      failures++;
      $display("FAIL reset_async out_vld=%b rows=%h required out_vld=0 rows=0", out_vld, obs);
    end
    in_vld = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (out_vld !== 1'b0) begin
      failures++;
      $display("FAIL reset_release out_vld=%b required 0", out_vld);
    end
    sb.delete();
  endtask

  task automatic test_directed();
    logic [15:0] dx [3];
    logic [15:0] dy [3];
    exp_t de [3];
    exp_t e;
    logic [15:0][31:0] obs;
    dx[0] = 16'h0007; dy[0] = 16'h0003;
    dx[1] = 16'hFFFF; dy[1] = 16'h0003;
    dx[2] = 16'hF00F; dy[2] = 16'hFFFF;
    de[0].vld = 1'b1; de[0].sum = 32'd21;       de[0].rows = '0;
    de[0].rows[0] = 32'h7; de[0].rows[1] = 32'hE;
    de[1].vld = 1'b1; de[1].sum = 32'h0002FFFD; de[1].rows = '0;
    de[1].rows[0] = 32'h0000FFFF; de[1].rows[1] = 32'h0001FFFE;
    de[2].vld = 1'b1; de[2].sum = 32'hF00E0FF1;
    for (int i = 0; i < 16; i++) de[2].rows[i] = 32'h0000F00F << i;
    for (int n = 0; n <= 3; n++) begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        obs = observed_rows();
        checks++;
        if (out_vld !== e.vld || obs !== e.rows) begin
          failures++;
          $display("FAIL directed_%0d rows out_vld=%b rows=%h required out_vld=%b rows=%h", n - 1, out_vld, obs, e.vld, e.rows);
        end
        checks++;
        if (sum_rows(obs) !== e.sum) begin
          failures++;
          $display("FAIL directed_%0d sum got=%h required=%h", n - 1, sum_rows(obs), e.sum);
        end
        $display("directed_%0d X=%h Y=%h sum=%h", n - 1, dx[n-1], dy[n-1], sum_rows(obs));
      end
      if (n < 3) begin
        in_vld = 1'b1; x = dx[n]; y = dy[n];
        sb.push_back(de[n]);
      end else begin
        in_vld = 1'b0;
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic [31:0] xy;
    logic [15:0][31:0] obs;
    for (int n = 0; n <= 10; n++) begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        obs = observed_rows();
        checks++;
        if (out_vld !== e.vld || obs !== e.rows || sum_rows(obs) !== e.sum) begin
          failures++;
          $display("FAIL b2b_%0d out_vld=%b rows=%h sum=%h required out_vld=%b rows=%h sum=%h", n - 1, out_vld, obs, sum_rows(obs), e.vld, e.rows, e.sum);
        end
        $display("b2b_%0d out_vld=%b sum=%h", n - 1, out_vld, sum_rows(obs));
      end
      if (n < 10) begin
        xy = 32'd40190218 + 32'(n);
        in_vld = 1'b1; x = xy[31:16]; y = xy[15:0];
        if (n == 0) begin
          e.vld = 1'b1; e.sum = 32'h0265 * 32'h410A; e.rows = '0;
          e.rows[1] = 32'h4CA; e.rows[3] = 32'h1328;
          e.rows[8] = 32'h26500; e.rows[14] = 32'h994000;
        end else begin
          e = model_exp(1'b1, xy[31:16], xy[15:0]);
        end
        sb.push_back(e);
      end else begin
        in_vld = 1'b0;
      end
    end
  endtask

  task automatic pick_operand(output logic [15:0] v);
    case ($urandom_range(0, 5))
      0:       v = 16'h0000;
      1:       v = 16'h0001;
      2:       v = 16'hFFFF;
      default: v = 16'($urandom);
    endcase
  endtask

  task automatic test_random();
    localparam int NRAND = 10000;
    exp_t e;
    logic [15:0] a, b;
    logic v;
    logic [15:0][31:0] obs;
    for (int n = 0; n <= NRAND; n++) begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        obs = observed_rows();
        checks++;
        if (out_vld !== e.vld || obs !== e.rows) begin
          failures++;
          $display("FAIL random_%0d out_vld=%b rows=%h required out_vld=%b rows=%h", n - 1, out_vld, obs, e.vld, e.rows);
        end
        if (e.vld) begin
          checks++;
          if (sum_rows(obs) !== e.sum) begin
            failures++;
            $display("FAIL random_%0d sum got=%h required=%h", n - 1, sum_rows(obs), e.sum);
          end
        end
      end
      if (n < NRAND) begin
        pick_operand(a);
        pick_operand(b);
        v = 1'($urandom_range(0, 1));
        in_vld = v; x = a; y = b;
        sb.push_back(model_exp(v, a, b));
      end else begin
        in_vld = 1'b0;
      end
    end
    $display("random pairs=%0d done", NRAND);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
